rr_response_router: RTL and testbench

- Return-path companion to the round-robin scheduling kernel.
- Each cycle the scheduler issues one grant per kernel (bank×port slot). This block carries each grant's consumer tag through a delay line matched to the PLM read latency.
- When the PLM data arrives, the block routes it back to the granted consumer and holds it in a per-consumer response register under a valid/ready handshake.
- Collisions and overflows are reported as sticky error flags.

---
 rtl/rr_response_router_if.sv | 29 ++
 rtl/rr_response_router.sv | 88 ++++++++
 tb/tb_rr_response_router.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rr_response_router_if.sv
// rr_response_router_if: grant, PLM return, response handshake and error flags for the response router.
interface rr_response_router_if #(
   parameter int VALUE_WIDTH = 8,
   parameter int NCONSUMERS  = 2,
   parameter int NBANKS      = 1,
   parameter int NPORTS      = 1
);
   localparam int NKERNELS = NBANKS * NPORTS;
   localparam int CID_W    = $clog2(NCONSUMERS);
   logic [NKERNELS-1:0]                   grant_valid;
   logic [NKERNELS-1:0][CID_W-1:0]        grant_id;
   logic [NKERNELS-1:0]                   grant_wr;
   logic [NKERNELS-1:0][VALUE_WIDTH-1:0]  plm_outputs;
   logic [NCONSUMERS-1:0]                 resp_valid;
   logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data;
   logic [NCONSUMERS-1:0]                 resp_wr;
   logic [NCONSUMERS-1:0]                 resp_ready;
   logic                                  collision;
   logic                                  overflow;
   logic                                  err_clear;
   modport master (
      output grant_valid, grant_id, grant_wr, plm_outputs, resp_ready, err_clear,
      input  resp_valid, resp_data, resp_wr, collision, overflow
   );
   modport slave (
      input  grant_valid, grant_id, grant_wr, plm_outputs, resp_ready, err_clear,
      output resp_valid, resp_data, resp_wr, collision, overflow
   );
endinterface

// File: rtl/rr_response_router.sv
// rr_response_router: delays grant tags by the PLM latency and routes returning PLM data to per-consumer response registers.
module rr_response_router #(
   parameter int VALUE_WIDTH = 8,
   parameter int NCONSUMERS  = 2,
   parameter int NBANKS      = 1,
   parameter int NPORTS      = 1,
   parameter int PLM_LATENCY = 1
) (
   input logic clk,
   input logic reset,
   rr_response_router_if.slave bus
);
   localparam int NKERNELS = NBANKS * NPORTS;
   localparam int CID_W    = $clog2(NCONSUMERS);
   localparam logic [CID_W:0] NC_L = (CID_W+1)'(NCONSUMERS);
   logic [PLM_LATENCY-1:0][NKERNELS-1:0]            tv_q, tw_q;
   logic [PLM_LATENCY-1:0][NKERNELS-1:0][CID_W-1:0] tid_q;
   logic [NKERNELS-1:0]                    rv, rw;
   logic [NKERNELS-1:0][CID_W-1:0]         rid;
   logic [NCONSUMERS-1:0]                  win, win_wr;
   logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] win_data;
   logic                                   coll_ev, ovf_ev;
   logic [NCONSUMERS-1:0]                  resp_valid_q, resp_valid_d, resp_wr_q, resp_wr_d;
   logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data_q, resp_data_d;
   logic                                   coll_q, coll_d, ovf_q, ovf_d;
   assign rv = tv_q[PLM_LATENCY-1];
   assign rw = tw_q[PLM_LATENCY-1];
   assign rid = tid_q[PLM_LATENCY-1];
   // Kernels are scanned in ascending order so the lowest-index hit claims the consumer.
   always_comb begin
      win      = '0;
      win_wr   = '0;
      win_data = '0;
      coll_ev  = 1'b0;
      for (int k = 0; k < NKERNELS; k++)
         if (rv[k]) begin
            if ({1'b0, rid[k]} >= NC_L) coll_ev = 1'b1;
            else if (win[rid[k]]) coll_ev = 1'b1;
            else begin
               win[rid[k]]      = 1'b1;
               win_wr[rid[k]]   = rw[k];
               win_data[rid[k]] = rw[k] ? '0 : bus.plm_outputs[k];
            end
         end
   end
   always_comb begin
      ovf_ev       = |(win & resp_valid_q & ~bus.resp_ready);
      resp_valid_d = win | (resp_valid_q & ~bus.resp_ready);
      resp_wr_d    = '0;
      resp_data_d  = '0;
      for (int c = 0; c < NCONSUMERS; c++) begin
         resp_wr_d[c]   = win[c] ? win_wr[c] : resp_wr_q[c];
         resp_data_d[c] = win[c] ? win_data[c] : resp_data_q[c];
      end
      coll_d = coll_ev | (coll_q & ~bus.err_clear);
      ovf_d  = ovf_ev | (ovf_q & ~bus.err_clear);
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         tv_q         <= '0;
         tw_q         <= '0;
         tid_q        <= '0;
         resp_valid_q <= '0;
         resp_wr_q    <= '0;
         resp_data_q  <= '0;
         coll_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         tv_q[0]  <= bus.grant_valid;
         tw_q[0]  <= bus.grant_wr;
         tid_q[0] <= bus.grant_id;
         for (int s = PLM_LATENCY - 1; s > 0; s--) begin
            tv_q[s]  <= tv_q[s-1];
            tw_q[s]  <= tw_q[s-1];
            tid_q[s] <= tid_q[s-1];
         end
         resp_valid_q <= resp_valid_d;
         resp_wr_q    <= resp_wr_d;
         resp_data_q  <= resp_data_d;
         coll_q       <= coll_d;
         ovf_q        <= ovf_d;
      end
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_wr    = resp_wr_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.collision  = coll_q;
   assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_rr_response_router.sv
// tb_rr_response_router: directed checks of routing, latency, write acks, collision, overflow and mid-flight reset.
module tb_rr_response_router;
   logic clk = 1'b0;
   logic rst_a, rst_b;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   rr_response_router_if #(.VALUE_WIDTH(8), .NCONSUMERS(2), .NBANKS(2), .NPORTS(1)) ifa ();
   rr_response_router_if #(.VALUE_WIDTH(8), .NCONSUMERS(2), .NBANKS(2), .NPORTS(1)) ifb ();
   rr_response_router #(.VALUE_WIDTH(8), .NCONSUMERS(2), .NBANKS(2), .NPORTS(1), .PLM_LATENCY(2))
      dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
   rr_response_router #(.VALUE_WIDTH(8), .NCONSUMERS(2), .NBANKS(2), .NPORTS(1), .PLM_LATENCY(3))
      dut_b (.clk(clk), .reset(rst_b), .bus(ifb));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic clr_a;
      ifa.grant_valid = '0; ifa.grant_id = '0; ifa.grant_wr = '0;
      ifa.plm_outputs = '0; ifa.err_clear = 1'b0;
   endtask
   task automatic clr_b;
      ifb.grant_valid = '0; ifb.grant_id = '0; ifb.grant_wr = '0;
      ifb.plm_outputs = '0; ifb.err_clear = 1'b0;
   endtask
   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      clr_a(); clr_b();
      ifa.resp_ready = '1; ifb.resp_ready = '1;
      tick(); tick();
      chk("rst_valid", ifa.resp_valid, 0);
      chk("rst_data", ifa.resp_data, 0);
      chk("rst_wr", ifa.resp_wr, 0);
      chk("rst_coll", ifa.collision, 0);
      chk("rst_ovf", ifa.overflow, 0);
      rst_a = 1'b1; rst_b = 1'b1;
      tick();
      // single read k0 -> c1
      ifa.grant_valid = 2'b01; ifa.grant_id[0] = 1'b1;
      tick(); clr_a();
      tick(); ifa.plm_outputs[0] = 8'hA5;
      tick(); clr_a();
      chk("rd_valid", ifa.resp_valid, 2'b10);
      chk("rd_data", ifa.resp_data[1], 8'hA5);
      chk("rd_wr", ifa.resp_wr[1], 0);
      tick();
      chk("rd_clear", ifa.resp_valid, 2'b00);
      // streaming k1 -> c0, one response per cycle
      for (int i = 0; i < 10; i++) begin
         clr_a();
         if (i < 8) begin ifa.grant_valid[1] = 1'b1; ifa.grant_id[1] = 1'b0; end
         if (i >= 2) ifa.plm_outputs[1] = 8'(i - 2);
         tick();
         if (i >= 2) begin
            chk("stream_valid", ifa.resp_valid[0], 1);
            chk("stream_data", ifa.resp_data[0], 32'(i - 2));
         end
      end
      chk("stream_ovf", ifa.overflow, 0);
      clr_a(); tick(); tick();
      // write ack
      ifa.grant_valid = 2'b01; ifa.grant_id[0] = 1'b0; ifa.grant_wr[0] = 1'b1;
      tick(); clr_a();
      tick(); ifa.plm_outputs[0] = 8'hFF;
      tick(); clr_a();
      chk("wr_valid", ifa.resp_valid[0], 1);
      chk("wr_flag", ifa.resp_wr[0], 1);
      chk("wr_data", ifa.resp_data[0], 0);
      tick();
      // collision; err_clear in the same cycle as the event loses
      ifa.grant_valid = 2'b11; ifa.grant_id = 2'b11;
      tick(); clr_a();
      tick(); ifa.plm_outputs[0] = 8'h11; ifa.plm_outputs[1] = 8'h22; ifa.err_clear = 1'b1;
      tick(); ifa.plm_outputs = '0;
      chk("coll_data", ifa.resp_data[1], 8'h11);
      chk("coll_valid", ifa.resp_valid, 2'b10);
      chk("coll_set", ifa.collision, 1);
      tick(); clr_a();
      chk("coll_clr", ifa.collision, 0);
      tick();
      // backpressure and overflow
      ifa.resp_ready[0] = 1'b0;
      ifa.grant_valid = 2'b01; ifa.grant_id[0] = 1'b0;
      tick();
      tick(); clr_a(); ifa.plm_outputs[0] = 8'h33;
      tick(); ifa.plm_outputs[0] = 8'h44; ifa.grant_valid = 2'b01; ifa.grant_id[0] = 1'b0;
      chk("bp1_data", ifa.resp_data[0], 8'h33);
      chk("bp1_ovf", ifa.overflow, 0);
      tick(); clr_a(); ifa.err_clear = 1'b1;
      chk("bp2_data", ifa.resp_data[0], 8'h44);
      chk("bp2_ovf", ifa.overflow, 1);
      tick(); clr_a(); ifa.plm_outputs[0] = 8'h55; ifa.resp_ready[0] = 1'b1;
      chk("bp_hold_valid", ifa.resp_valid[0], 1);
      chk("bp_hold_data", ifa.resp_data[0], 8'h44);
      chk("bp_ovf_clr", ifa.overflow, 0);
      tick(); clr_a();
      chk("bp3_valid", ifa.resp_valid[0], 1);
      chk("bp3_data", ifa.resp_data[0], 8'h55);
      chk("bp3_ovf", ifa.overflow, 0);
      tick();
      chk("bp_drain", ifa.resp_valid[0], 0);
      // latency-3 instance: held response, then reset mid-flight
      ifb.resp_ready[0] = 1'b0;
      ifb.grant_valid = 2'b10; ifb.grant_id[1] = 1'b0;
      tick(); clr_b();
      tick();
      tick(); ifb.plm_outputs[1] = 8'h66;
      tick(); clr_b();
      chk("l3_valid", ifb.resp_valid[0], 1);
      chk("l3_data", ifb.resp_data[0], 8'h66);
      ifb.grant_valid = 2'b01; ifb.grant_id[0] = 1'b0;
      tick(); clr_b(); rst_b = 1'b0;
      #1;
      chk("mr_valid", ifb.resp_valid, 0);
      chk("mr_data", ifb.resp_data, 0);
      chk("mr_wr", ifb.resp_wr, 0);
      chk("mr_coll", ifb.collision, 0);
      chk("mr_ovf", ifb.overflow, 0);
      tick(); rst_b = 1'b1;
      tick(); ifb.plm_outputs[0] = 8'h77;
      tick(); clr_b();
      chk("mr_no_resp_t4", ifb.resp_valid, 0);
      tick();
      chk("mr_no_resp_t5", ifb.resp_valid, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
